// File: rtl/mac_accumulator_if.sv
// Operand stream into the MAC sequencer: one a/b pair per valid/ready transfer.
interface mac_accumulator_if #(
  parameter int OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;

  modport master (output in_valid, output a, output b, input in_ready);
  modport slave  (input in_valid, input a, input b, output in_ready);
endinterface

// File: rtl/mac_accumulator.sv
// Sequences operand pairs through the start/done multiplier and accumulates
// LEN products into a dot-product result with sticky carry-out detection.
module mac_accumulator #(
  parameter int OPW   = 4,
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mac_accumulator_if.slave           in_if,
  input  logic                       clear,
  output logic                       mult_start,
  output logic [OPW-1:0]             mult_a,
  output logic [OPW-1:0]             mult_b,
  input  logic                       mult_done,
  input  logic [2*OPW-1:0]           mult_out,
  output logic [ACC_W-1:0]           acc_out,
  output logic [$clog2(LEN+1)-1:0]   count,
  output logic [ACC_W-1:0]           res,
  output logic                       res_valid,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(LEN+1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               transfer;
  logic               accumulate;
  logic               group_done;
  logic [SUM_W-1:0]   sum;
  logic [ACC_W-1:0]   acc_next;
  logic               carry;

  assign sum        = SUM_W'(acc_out) + SUM_W'(mult_out);
  assign acc_next   = sum[ACC_W-1:0];
  assign carry      = sum[ACC_W];
  assign group_done = accumulate && (count == CNT_W'(LEN-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Accumulate fires only on done returning high after it was seen low,
  // so the product sampled always belongs to the pair currently held.
  always_comb begin
    state_next     = state;
    in_if.in_ready = 1'b0;
    mult_start     = 1'b0;
    transfer       = 1'b0;
    accumulate     = 1'b0;
    case (state)
      IDLE: begin
        in_if.in_ready = mult_done & ~clear;
        transfer       = in_if.in_valid & mult_done & ~clear;
        if (transfer) state_next = START;
      end
      START: begin
        mult_start = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!mult_done) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mult_done) begin
          accumulate = ~clear;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a    <= '0;
      mult_b    <= '0;
      acc_out   <= '0;
      count     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (transfer) begin
        mult_a <= in_if.a;
        mult_b <= in_if.b;
      end
      if (clear) begin
        acc_out  <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (accumulate) begin
        if (group_done) begin
          res       <= acc_next;
          res_valid <= 1'b1;
          acc_out   <= '0;
          count     <= '0;
        end else begin
          acc_out <= acc_next;
          count   <= count + CNT_W'(1);
        end
        overflow <= overflow | carry;
      end else if (res_valid) begin
        // Overflow describes the finished group only through its result cycle.
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequencing and accumulation stage that sits directly downstream of the team's start/done 4x4 multiplier.
- Accepts operand pairs on a valid/ready handshake, holds each pair stable on the multiplier inputs, and pulses the multiplier start.
- Waits for the multiplier's full done cycle, then adds the 8-bit product into a wide accumulator.
- After LEN products it emits the dot-product result for one cycle and auto-clears.

Parameters:
OPW, 4, operand width per input (a, b)
ACC_W, 16, accumulator/result width; must be >= 2*OPW
LEN, 4, products per dot-product (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block accepts a pair this cycle
a  input  OPW  operand A
b  input  OPW  operand B
clear  input  1  synchronous flush of accumulation
mult_start  output  1  start pulse to multiplier
mult_a  output  OPW  registered operand A to multiplier
mult_b  output  OPW  registered operand B to multiplier
mult_done  input  1  multiplier done (level; high when multiplier idle)
mult_out  input  2*OPW  multiplier product (valid while mult_done high after completion)
acc_out  output  ACC_W  running accumulator value
count  output  clog2(LEN+1)  products accumulated in current group
res  output  ACC_W  last completed dot-product
res_valid  output  1  one-cycle pulse when res updates
overflow  output  1  sticky: carry out of ACC_W in current group

Behaviour:
- Reset (async, any state): FSM=IDLE; mult_a, mult_b, acc_out, count, res = 0; res_valid, overflow, mult_start = 0.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - in_ready = mult_done & ~clear; all other states drive in_ready = 0.
  - Transfer = in_valid & in_ready: latch a->mult_a, b->mult_b, go START.
- START:
  - mult_start = 1 for exactly this cycle (combinational from state); go WAIT_BUSY.
- WAIT_BUSY:
  - Stay until mult_done = 0, then go WAIT_DONE.
  - mult_done is high while the multiplier idles, so a start acknowledged by the multiplier always shows done falling.
- WAIT_DONE:
  - Stay until mult_done = 1.
  - On that edge: acc_next = acc_out + zero-extended mult_out; count += 1; go IDLE.
- mult_a/mult_b hold their value from START through WAIT_DONE. The multiplier reads its operand inputs directly during computation, so they must not change until done returns.
- Width/overflow rules:
  - Addition is modulo 2^ACC_W.
  - A carry out sets overflow. It stays set until group completion, clear, or rst.
- Group completion: when the accumulate makes count reach LEN, on the same edge:
  - res <= acc_next; res_valid = 1 for one cycle.
  - acc_out <= 0; count <= 0.
  - overflow holds the final group status through the res_valid cycle and clears on the next edge.
- Latency with the team multiplier (5 busy cycles):
  - Transfer at edge T0, multiplier samples start at T1, acc_out updates at T7.
  - Next in_ready is high in the cycle after T7.
- clear (synchronous, any state):
  - acc_out, count, overflow <= 0; FSM <= IDLE; in-flight product discarded; res/res_valid unaffected.
  - If clear coincides with group completion, clear wins and res_valid is not pulsed.
  - After clear mid-operation, the block waits in IDLE (in_ready low) until mult_done returns high, then accepts again.
- Single-cycle mult_done glitches: none expected; no timeout logic.

Test Plan:
- LEN=4: pairs (8,3),(11,6),(5,13),(15,15) with in_valid held high -> acc_out steps 24, 90, 155, then res=380 with res_valid exactly one cycle; acc_out=0, count=0, overflow=0 afterwards.
- Backpressure: assert in_valid with (7,7) one cycle after a transfer and keep it high -> in_ready low through WAIT_DONE; pair accepted exactly once; mult_a/mult_b constant from START until mult_done rises; acc_out grows by 49 once.
- ACC_W=8, LEN=2: (15,15),(15,15) -> res=194 (450 mod 256), overflow=1 during res_valid cycle, 0 next cycle.
- Clear mid-operation: after (9,9) is accepted, pulse clear during WAIT_DONE -> acc_out stays 0, count=0, no res_valid. Next pair (2,3) is accepted only after mult_done high, giving acc_out=6.
- Reset mid-operation: assert rst during WAIT_BUSY -> all outputs 0 immediately (async), mult_start=0. After release plus multiplier return to idle, (4,4) accumulates to 16.
- Latency check: single pair (1,1) -> mult_start high in cycle after transfer; acc_out=1 exactly 7 edges after transfer edge.
